// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle between the timing generator and its consumers.
// The optional frameCount signal exists only when VTIMING_FRAME_COUNT_EN is defined.
interface vga_timing_gen_if;
  logic       enable;
  logic [9:0] hPos;
  logic [9:0] vPos;
  logic [9:0] nextVPos;
  logic       hsync;
  logic       vsync;
  logic       pixelActive;
  logic       nextFrameActive;
  logic       hsyncStarting;
  logic       lineStarting;
  logic       lineEnding;
  logic       frameStarting;
`ifdef VTIMING_FRAME_COUNT_EN
  logic [15:0] frameCount;
`endif

  // Timing generator side.
  modport master (
`ifdef VTIMING_FRAME_COUNT_EN
    output frameCount,
`endif
    input  enable,
    output hPos,
    output vPos,
    output nextVPos,
    output hsync,
    output vsync,
    output pixelActive,
    output nextFrameActive,
    output hsyncStarting,
    output lineStarting,
    output lineEnding,
    output frameStarting
  );

  // Consumer side (layer engine, display pins).
  modport slave (
`ifdef VTIMING_FRAME_COUNT_EN
    input  frameCount,
`endif
    output enable,
    input  hPos,
    input  vPos,
    input  nextVPos,
    input  hsync,
    input  vsync,
    input  pixelActive,
    input  nextFrameActive,
    input  hsyncStarting,
    input  lineStarting,
    input  lineEnding,
    input  frameStarting
  );
endinterface

// File: rtl/vga_timing_gen.sv
// Free-running VGA raster timing generator in the pixel clock domain.
// Every output is decoded from the next-state counters and registered, so each strobe
// is high in exactly the cycle where hPos/vPos hold the value it names.
// lineStarting/lineEnding lead the active region by LINE_LEAD pixels to cover the
// layer FIFO and blend pipeline latency.
// Optional: define VTIMING_FRAME_COUNT_EN to add a 16-bit frameCount output.
module vga_timing_gen #(
  parameter int unsigned H_ACTIVE  = 640,
  parameter int unsigned H_FP      = 16,
  parameter int unsigned H_SYNC    = 96,
  parameter int unsigned H_BP      = 48,
  parameter int unsigned V_ACTIVE  = 480,
  parameter int unsigned V_FP      = 10,
  parameter int unsigned V_SYNC    = 2,
  parameter int unsigned V_BP      = 33,
  parameter int unsigned LINE_LEAD = 6
) (
  input logic              clkPixel,
  input logic              reset,
  vga_timing_gen_if.master bus
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] HLast        = 10'(H_TOTAL - 1);
  localparam logic [9:0] VLast        = 10'(V_TOTAL - 1);
  localparam logic [9:0] HActive      = 10'(H_ACTIVE);
  localparam logic [9:0] VActive      = 10'(V_ACTIVE);
  localparam logic [9:0] HSyncStart   = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] HSyncEnd     = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] VSyncStart   = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] VSyncEnd     = 10'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [9:0] LineStartPos = 10'(H_TOTAL - LINE_LEAD);
  localparam logic [9:0] LineEndPos   = 10'(H_ACTIVE - LINE_LEAD);

  // The lead must fit inside the back porch so lineStarting lands on the previous line.
  if (LINE_LEAD < 1 || LINE_LEAD > H_BP) begin : gBadLineLead
    $error("vga_timing_gen: LINE_LEAD must be in 1..H_BP");
  end

  logic [9:0] hPosQ, hPosD;
  logic [9:0] vPosQ, vPosD;
  logic [9:0] nextVPosQ, nextVPosD;
  logic       hsyncQ, hsyncD;
  logic       vsyncQ, vsyncD;
  logic       pixelActiveQ, pixelActiveD;
  logic       nextFrameActiveQ, nextFrameActiveD;
  logic       hsyncStartingQ, hsyncStartingD;
  logic       lineStartingQ, lineStartingD;
  logic       lineEndingQ, lineEndingD;
  logic       frameStartingQ, frameStartingD;

  // Next raster position; holds when enable is low.
  always_comb begin
    hPosD     = hPosQ;
    vPosD     = vPosQ;
    nextVPosD = nextVPosQ;
    if (bus.enable) begin
      if (hPosQ == HLast) begin
        hPosD     = '0;
        vPosD     = nextVPosQ;
        nextVPosD = (nextVPosQ == VLast) ? '0 : nextVPosQ + 10'd1;
      end else begin
        hPosD = hPosQ + 10'd1;
      end
    end
  end

  // Decode levels and strobes from the next position; strobes are suppressed while frozen.
  always_comb begin
    hsyncD           = !((hPosD >= HSyncStart) && (hPosD < HSyncEnd));
    vsyncD           = !((vPosD >= VSyncStart) && (vPosD < VSyncEnd));
    pixelActiveD     = (hPosD < HActive) && (vPosD < VActive);
    nextFrameActiveD = (nextVPosD < VActive);
    hsyncStartingD   = bus.enable && (hPosD == HSyncStart);
    lineStartingD    = bus.enable && (hPosD == LineStartPos) && (nextVPosD < VActive);
    lineEndingD      = bus.enable && (hPosD == LineEndPos) && (vPosD < VActive);
    frameStartingD   = bus.enable && (hPosD == '0) && (vPosD == '0);
  end

  // Register counters and all decoded outputs.
  always_ff @(posedge clkPixel or posedge reset) begin
    if (reset) begin
      hPosQ            <= '0;
      vPosQ            <= '0;
      nextVPosQ        <= 10'd1;
      hsyncQ           <= 1'b1;
      vsyncQ           <= 1'b1;
      pixelActiveQ     <= 1'b1;
      nextFrameActiveQ <= 1'b1;
      hsyncStartingQ   <= 1'b0;
      lineStartingQ    <= 1'b0;
      lineEndingQ      <= 1'b0;
      frameStartingQ   <= 1'b1;
    end else begin
      hPosQ            <= hPosD;
      vPosQ            <= vPosD;
      nextVPosQ        <= nextVPosD;
      hsyncQ           <= hsyncD;
      vsyncQ           <= vsyncD;
      pixelActiveQ     <= pixelActiveD;
      nextFrameActiveQ <= nextFrameActiveD;
      hsyncStartingQ   <= hsyncStartingD;
      lineStartingQ    <= lineStartingD;
      lineEndingQ      <= lineEndingD;
      frameStartingQ   <= frameStartingD;
    end
  end

`ifdef VTIMING_FRAME_COUNT_EN
  logic [15:0] frameCountQ, frameCountD;

  // Count frame starts reached by advancing; the reset-release frame is not counted.
  always_comb begin
    frameCountD = frameStartingD ? frameCountQ + 16'd1 : frameCountQ;
  end

  // Frame counter register.
  always_ff @(posedge clkPixel or posedge reset) begin
    if (reset) begin
      frameCountQ <= '0;
    end else begin
      frameCountQ <= frameCountD;
    end
  end

  assign bus.frameCount = frameCountQ;
`endif

  assign bus.hPos            = hPosQ;
  assign bus.vPos            = vPosQ;
  assign bus.nextVPos        = nextVPosQ;
  assign bus.hsync           = hsyncQ;
  assign bus.vsync           = vsyncQ;
  assign bus.pixelActive     = pixelActiveQ;
  assign bus.nextFrameActive = nextFrameActiveQ;
  assign bus.hsyncStarting   = hsyncStartingQ;
  assign bus.lineStarting    = lineStartingQ;
  assign bus.lineEnding      = lineEndingQ;
  assign bus.frameStarting   = frameStartingQ;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench for vga_timing_gen using a shrunken raster so whole frames fit
// in a short run. The reference model tracks only the number of advancing cycles since
// reset and derives position and every output from that count.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 4, HS = 6, HB = 8;
  localparam int VA = 10, VF = 2, VS = 2, VB = 3;
  localparam int LL = 3;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clkPixel = 1'b0;
  logic reset    = 1'b1;

  vga_timing_gen_if bus ();

  vga_timing_gen #(
    .H_ACTIVE (HA),
    .H_FP     (HF),
    .H_SYNC   (HS),
    .H_BP     (HB),
    .V_ACTIVE (VA),
    .V_FP     (VF),
    .V_SYNC   (VS),
    .V_BP     (VB),
    .LINE_LEAD(LL)
  ) dut (
    .clkPixel(clkPixel),
    .reset   (reset),
    .bus     (bus)
  );

  always #5 clkPixel = ~clkPixel;

  int nCheck = 0;
  int nPass  = 0;
  int nFail  = 0;

  // Reference model state.
  int          n  = 0;    // advancing cycles since reset release
  bit          pv = 1'b1; // last edge was reset or an enabled advance (strobes may fire)
  logic [15:0] fc = '0;   // expected frame count

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nCheck++;
    assert (obs === exp) nPass++;
    else begin
      nFail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int curH();
    return n % HT;
  endfunction

  function automatic int curV();
    return (n / HT) % VT;
  endfunction

  task automatic checkOutputs();
    int h, v, nv;
    h  = curH();
    v  = curV();
    nv = (v + 1) % VT;
    chk("hPos", 32'(bus.hPos), h);
    chk("vPos", 32'(bus.vPos), v);
    chk("nextVPos", 32'(bus.nextVPos), nv);
    chk("hsync", 32'(bus.hsync), 32'(!(h >= HA + HF && h < HA + HF + HS)));
    chk("vsync", 32'(bus.vsync), 32'(!(v >= VA + VF && v < VA + VF + VS)));
    chk("pixelActive", 32'(bus.pixelActive), 32'(h < HA && v < VA));
    chk("nextFrameActive", 32'(bus.nextFrameActive), 32'(nv < VA));
    chk("hsyncStarting", 32'(bus.hsyncStarting), 32'(pv && h == HA + HF));
    chk("lineStarting", 32'(bus.lineStarting), 32'(pv && h == HT - LL && nv < VA));
    chk("lineEnding", 32'(bus.lineEnding), 32'(pv && h == HA - LL && v < VA));
    chk("frameStarting", 32'(bus.frameStarting), 32'(pv && h == 0 && v == 0));
`ifdef VTIMING_FRAME_COUNT_EN
    chk("frameCount", 32'(bus.frameCount), 32'(fc));
`endif
  endtask

  task automatic modelReset();
    n  = 0;
    pv = 1'b1;
    fc = '0;
  endtask

  // One clock with the given enable, then update the model and compare.
  task automatic step(input logic en);
    bus.enable = en;
    @(posedge clkPixel);
    #1;
    if (reset) begin
      modelReset();
    end else if (en) begin
      n++;
      pv = 1'b1;
      if (n % FRAME == 0) fc = fc + 16'd1;
    end else begin
      pv = 1'b0;
    end
    checkOutputs();
  endtask

  // Advance with enable=1 until the model reaches (h, v); bounded by two frames.
  task automatic runTo(input int h, input int v);
    for (int i = 0; i < 2 * FRAME && !(curH() == h && curV() == v); i++) step(1'b1);
    chk("reachPos", 32'(curH() == h && curV() == v), 32'd1);
  endtask

  int lsCount, hsLowCount, fsCount;

  initial begin
    bus.enable = 1'b0;

    // Reset values while reset is held.
    step(1'b1);
    step(1'b0);
    reset = 1'b0;

    // One full frame: model checks every cycle, plus aggregate counts.
    lsCount    = 0;
    hsLowCount = 0;
    fsCount    = 0;
    for (int i = 1; i <= FRAME; i++) begin
      step(1'b1);
      if (bus.lineStarting) lsCount++;
      if (i < HT && !bus.hsync) hsLowCount++;
      if (bus.frameStarting) fsCount++;
    end
    chk("lineStartingPerFrame", 32'(lsCount), VA);
    chk("hsyncLowWidth", 32'(hsLowCount), HS);
    chk("frameStartOnce", 32'(fsCount), 1);
    chk("frameWrapH", 32'(bus.hPos), 0);
    chk("frameWrapV", 32'(bus.vPos), 0);

    // Freeze right on a lineStarting pulse: one pulse only, position held, then resume.
    runTo(HT - LL, 3);
    chk("freezePulse", 32'(bus.lineStarting), 1);
    lsCount = 0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      if (bus.lineStarting) lsCount++;
    end
    chk("freezeNoRepeat", 32'(lsCount), 0);
    step(1'b1);
    chk("resumeH", 32'(bus.hPos), HT - LL + 1);

    // Randomized enable pattern.
    for (int i = 0; i < 2000; i++) step($urandom_range(0, 3) != 0);

    // Asynchronous reset mid-line: outputs return immediately, then a full fresh frame.
    runTo(10, 5);
    reset = 1'b1;
    #1;
    modelReset();
    checkOutputs();
    for (int i = 0; i < 3; i++) step(1'b1);
    reset = 1'b0;
    fsCount = 0;
    for (int i = 1; i < FRAME; i++) begin
      step(1'b1);
      if (bus.frameStarting) fsCount++;
    end
    chk("noEarlyFrameStart", 32'(fsCount), 0);
    step(1'b1);
    chk("frameStartAfterReset", 32'(bus.frameStarting), 1);

`ifdef VTIMING_FRAME_COUNT_EN
    // Fresh reset, three full frames, then a forced wrap from 0xFFFF.
    reset = 1'b1;
    step(1'b1);
    reset = 1'b0;
    for (int i = 0; i < 3 * FRAME; i++) step(1'b1);
    chk("frameCount3", 32'(bus.frameCount), 3);
    runTo(HT - 1, VT - 1);
    force dut.frameCountQ = 16'hFFFF;
    #1;
    release dut.frameCountQ;
    fc = 16'hFFFF;
    step(1'b1);
    chk("frameCountWrap", 32'(bus.frameCount), 0);
`endif

    $display("%0d/%0d checks passed", nPass, nCheck);
    $finish;
  end

endmodule
